// File: rtl/run_scan_ctrl.sv
// ----------------------------------------------------------------------------
// run_scan_ctrl
//
// Session controller that takes parallel words over a valid/ready handshake
// and scans them MSB-first, one bit per clock, looking for runs of equal bits.
// Runs carry across word boundaries and across idle gaps between words. Every
// run that reaches the configured length is flagged on det_out and counted
// once on det_count (saturating).
//
// Ports:
//   clk          system clock, rising edge
//   nReset       asynchronous active-low reset
//   start        begin a session (sampled only while idle)
//   run_len_cfg  required run length, latched on start (values < 2 become 2)
//   word_valid   producer has a word
//   word_data    word to scan, MSB first
//   word_last    marks word_data as the final word of the session
//   word_ready   controller accepts a word this cycle
//   busy         session in progress (loading or shifting)
//   det_out      registered: current run length >= configured length
//   det_count    number of runs that reached the configured length
//   done         one-cycle pulse at the end of a session
// ----------------------------------------------------------------------------
module run_scan_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 4,
    parameter int RL_W  = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [RL_W-1:0]  run_len_cfg,
    input  logic             word_valid,
    input  logic [W-1:0]     word_data,
    input  logic             word_last,
    output logic             word_ready,
    output logic             busy,
    output logic             det_out,
    output logic [CNT_W-1:0] det_count,
    output logic             done
);

    localparam int IDX_W = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [RL_W-1:0]    cfg_q,       cfg_d;
    logic [W-1:0]       shreg_q,     shreg_d;
    logic               last_q,      last_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [RL_W-1:0]    run_q,       run_d;
    logic               prev_q,      prev_d;
    logic               first_q,     first_d;
    logic               det_out_q,   det_out_d;
    logic [CNT_W-1:0]   det_count_q, det_count_d;

    logic               bit_cur;
    logic [RL_W-1:0]    run_next;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            cfg_q       <= RL_W'(2);
            shreg_q     <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            run_q       <= '0;
            prev_q      <= 1'b0;
            first_q     <= 1'b1;
            det_out_q   <= 1'b0;
            det_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            shreg_q     <= shreg_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            first_q     <= first_d;
            det_out_q   <= det_out_d;
            det_count_q <= det_count_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/default value before the case so no
        // path through the block leaves one unassigned (no inferred latches).
        state_d     = state_q;
        cfg_d       = cfg_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        idx_d       = idx_q;
        run_d       = run_q;
        prev_d      = prev_q;
        first_d     = first_q;
        det_out_d   = det_out_q;
        det_count_d = det_count_q;
        bit_cur     = shreg_q[W-1];
        run_next    = run_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // A run length below 2 would flag every single bit.
                    cfg_d       = (run_len_cfg < RL_W'(2)) ? RL_W'(2) : run_len_cfg;
                    det_count_d = '0;
                    det_out_d   = 1'b0;
                    run_d       = '0;
                    first_d     = 1'b1;
                    state_d     = LOAD;
                end
            end

            LOAD: begin
                if (word_valid) begin
                    shreg_d = word_data;
                    last_d  = word_last;
                    idx_d   = IDX_W'(W - 1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // The run counter saturates at cfg so a long run cannot wrap
                // and re-trigger; run_q < cfg makes the count fire once per run.
                if (first_q || (bit_cur != prev_q)) begin
                    run_next = RL_W'(1);
                end else if (run_q >= cfg_q) begin
                    run_next = cfg_q;
                end else begin
                    run_next = run_q + RL_W'(1);
                end

                run_d     = run_next;
                prev_d    = bit_cur;
                first_d   = 1'b0;
                det_out_d = (run_next == cfg_q);

                if ((run_next == cfg_q) && (run_q < cfg_q) && (det_count_q != '1)) begin
                    det_count_d = det_count_q + CNT_W'(1);
                end

                shreg_d = {shreg_q[W-2:0], 1'b0};

                if (idx_q == '0) begin
                    state_d = last_q ? DONE : LOAD;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign word_ready = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign det_out    = det_out_q;
    assign det_count  = det_count_q;

endmodule

// File: tb/tb_run_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_run_scan_ctrl
//
// Self-checking bench for run_scan_ctrl. A behavioural model predicts det_out
// for every scanned bit when a word is handed over; the predictions are queued
// and popped as the DUT scans. Session totals are checked against both the
// model and hand-derived constants.
// ----------------------------------------------------------------------------
module tb_run_scan_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int RL_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             nReset;
    logic             start;
    logic [RL_W-1:0]  run_len_cfg;
    logic             word_valid;
    logic [W-1:0]     word_data;
    logic             word_last;
    logic             word_ready;
    logic             busy;
    logic             det_out;
    logic [CNT_W-1:0] det_count;
    logic             done;

    int errors = 0;
    int checks = 0;

    // Model state: unbounded run length in an int, detection when it crosses cfg.
    int   m_cfg;
    int   m_run;
    bit   m_prev;
    bit   m_first;
    int   m_cnt;
    bit   m_det;
    bit   exp_q[$];

    run_scan_ctrl #(.W(W), .CNT_W(CNT_W), .RL_W(RL_W)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .start       (start),
        .run_len_cfg (run_len_cfg),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_last   (word_last),
        .word_ready  (word_ready),
        .busy        (busy),
        .det_out     (det_out),
        .det_count   (det_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    // All tasks begin and end just after a falling edge.

    task automatic start_session(input int cfg);
        run_len_cfg = RL_W'(cfg);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        m_cfg = (cfg < 2) ? 2 : cfg;
        m_run = 0;
        m_first = 1'b1;
        m_cnt = 0;
        m_det = 1'b0;
        checks++;
        if (busy !== 1'b1 || word_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_load: busy=%b ready=%b required 1/1", busy, word_ready);
        end
    endtask

    task automatic model_word(input logic [W-1:0] data);
        bit b;
        for (int i = W - 1; i >= 0; i--) begin
            b = data[i];
            if (m_first || b != m_prev) m_run = 1;
            else m_run = m_run + 1;
            if (m_run == m_cfg && m_cnt < CNT_MAX) m_cnt++;
            m_prev = b;
            m_first = 1'b0;
            m_det = (m_run >= m_cfg);
            exp_q.push_back(m_det);
        end
    endtask

    task automatic send_word(input logic [W-1:0] data, input bit last, input int gap);
        int  waited;
        bit  exp;
        for (int g = 0; g < gap; g++) begin
            checks++;
            if (word_ready !== 1'b1 || det_out !== m_det) begin
                errors++;
                $display("FAIL load_hold: ready=%b det_out=%b required 1/%b", word_ready, det_out, m_det);
            end
            @(posedge clk); @(negedge clk);
        end
        word_valid = 1'b1;
        word_data  = data;
        word_last  = last;
        waited = 0;
        while (word_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        if (word_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: word_ready=%b required 1", word_ready);
            word_valid = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        word_valid = 1'b0;
        word_data  = '0;
        model_word(data);
        for (int i = 0; i < W; i++) begin
            @(posedge clk); @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (det_out !== exp) begin
                errors++;
                $display("FAIL det_out bit%0d of %h: got %b required %b", i, data, det_out, exp);
            end
        end
        if (last) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || det_count !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL session_end: done=%b busy=%b count=%0d required 1/0/%0d",
                         done, busy, det_count, m_cnt);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (done !== 1'b0 || det_count !== CNT_W'(m_cnt) || det_out !== m_det) begin
                errors++;
                $display("FAIL done_pulse: done=%b count=%0d det=%b required 0/%0d/%b",
                         done, det_count, det_out, m_cnt, m_det);
            end
        end else begin
            checks++;
            if (word_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL back_to_load: ready=%b done=%b required 1/0", word_ready, done);
            end
        end
    endtask

    task automatic expect_count(input string name, input int req);
        checks++;
        if (det_count !== CNT_W'(req)) begin
            errors++;
            $display("FAIL %s: det_count=%0d required %0d", name, det_count, req);
        end
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        start = 1'b0;
        run_len_cfg = '0;
        word_valid = 1'b0;
        word_data = '0;
        word_last = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({word_ready, busy, det_out, det_count, done} !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b det=%b count=%0d done=%b required all 0",
                     word_ready, busy, det_out, det_count, done);
        end
        nReset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_runs;
        start_session(4);
        send_word(8'b0000_1111, 1'b1, 0);
        expect_count("two_runs", 2);
    endtask

    task automatic test_alternating;
        start_session(4);
        send_word(8'hAA, 1'b1, 0);
        expect_count("alternating", 0);
    endtask

    task automatic test_boundary;
        start_session(4);
        send_word(8'b0000_0011, 1'b0, 0);
        send_word(8'b1100_0000, 1'b1, 3);
        expect_count("boundary", 3);
    endtask

    task automatic test_cfg_clamp;
        start_session(0);
        run_len_cfg = RL_W'(8);
        send_word(8'b1100_1100, 1'b1, 0);
        expect_count("cfg_clamp", 4);
    endtask

    task automatic test_saturation;
        start_session(2);
        send_word(8'b1100_1100, 1'b0, 0);
        send_word(8'b1100_1100, 1'b0, 0);
        send_word(8'b1100_1100, 1'b0, 0);
        expect_count("sat_12", 12);
        send_word(8'b1100_1100, 1'b1, 0);
        expect_count("sat_15", CNT_MAX);
    endtask

    task automatic test_abort;
        bit saw_done;
        start_session(4);
        word_valid = 1'b1;
        word_data  = 8'b0000_1111;
        word_last  = 1'b1;
        @(posedge clk); @(negedge clk);
        word_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #2 nReset = 1'b0;
        #1;
        checks++;
        if ({word_ready, busy, det_out, det_count, done} !== '0) begin
            errors++;
            $display("FAIL abort: ready=%b busy=%b det=%b count=%0d done=%b required all 0",
                     word_ready, busy, det_out, det_count, done);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        nReset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: saw_done=%b busy=%b required 0/0", saw_done, busy);
        end
        exp_q.delete();
        test_two_runs();
    endtask

    initial begin
        test_reset();
        test_two_runs();
        test_alternating();
        test_boundary();
        test_cfg_clamp();
        test_saturation();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
